// File: rtl/guess_checker.sv
// guess_checker: number-guessing round controller.
// Button histories detect press/release edges. A five-state FSM seeds a secret
// from the random source, scores guesses against it and reveals it at round end.
module guess_checker #(
   parameter int MAX_TRIES = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seed_button,
   input  logic [4:0] rand_num,
   input  logic [4:0] guess,
   input  logic       guess_button,
   output logic       too_high,
   output logic       too_low,
   output logic       match,
   output logic [3:0] tries_left,
   output logic [2:0] state,
   output logic [4:0] reveal
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEEDING = 3'd1,
      PLAY    = 3'd2,
      WIN     = 3'd3,
      LOSE    = 3'd4
   } state_e;

   localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

   state_e     state_q, state_d;
   logic [4:0] secret_q, secret_d;
   logic [3:0] tries_q, tries_d;
   logic       too_high_q, too_high_d;
   logic       too_low_q, too_low_d;
   logic       match_q, match_d;
   logic [4:0] reveal_q, reveal_d;
   logic       seed_hist_q, guess_hist_q;

   // Buttons are active-low, so a press is a 1->0 step and a release a 0->1 step.
   logic seed_press_s, seed_release_s, guess_press_s;
   assign seed_press_s   = seed_hist_q & ~seed_button;
   assign seed_release_s = ~seed_hist_q & seed_button;
   assign guess_press_s  = guess_hist_q & ~guess_button;

   // Button history registers; reset to released so a button held through reset
   // is seen as a press on the first active cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seed_hist_q  <= 1'b1;
         guess_hist_q <= 1'b1;
      end else begin
         seed_hist_q  <= seed_button;
         guess_hist_q <= guess_button;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         secret_q   <= 5'd0;
         tries_q    <= 4'd0;
         too_high_q <= 1'b0;
         too_low_q  <= 1'b0;
         match_q    <= 1'b0;
         reveal_q   <= 5'd0;
      end else begin
         state_q    <= state_d;
         secret_q   <= secret_d;
         tries_q    <= tries_d;
         too_high_q <= too_high_d;
         too_low_q  <= too_low_d;
         match_q    <= match_d;
         reveal_q   <= reveal_d;
      end
   end

   // Next-state logic: each state reacts only to the events it cares about,
   // so simultaneous events are never queued.
   always_comb begin
      state_d    = state_q;
      secret_d   = secret_q;
      tries_d    = tries_q;
      too_high_d = too_high_q;
      too_low_d  = too_low_q;
      match_d    = match_q;
      reveal_d   = 5'd0;

      case (state_q)
         IDLE: begin
            if (seed_press_s) begin
               state_d    = SEEDING;
               too_high_d = 1'b0;
               too_low_d  = 1'b0;
               match_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SEEDING: begin
            if (seed_release_s) begin
               secret_d = rand_num;
               tries_d  = MAX_T;
               state_d  = PLAY;
            end else begin
               state_d = SEEDING;
            end
         end
         PLAY: begin
            if (guess_press_s) begin
               too_high_d = (guess > secret_q);
               too_low_d  = (guess < secret_q);
               match_d    = (guess == secret_q);
               if (guess == secret_q) begin
                  state_d = WIN;
               end else if (tries_q <= 4'd1) begin
                  // Last try used (the <= also guards against underflow).
                  tries_d = 4'd0;
                  state_d = LOSE;
               end else begin
                  tries_d = tries_q - 4'd1;
               end
            end else begin
               state_d = PLAY;
            end
         end
         WIN, LOSE: begin
            if (seed_press_s) begin
               state_d    = SEEDING;
               too_high_d = 1'b0;
               too_low_d  = 1'b0;
               match_d    = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The secret is only visible once the round has ended.
      if (state_d == WIN || state_d == LOSE) begin
         reveal_d = secret_d;
      end else begin
         reveal_d = 5'd0;
      end
   end

   assign too_high   = too_high_q;
   assign too_low    = too_low_q;
   assign match      = match_q;
   assign tries_left = tries_q;
   assign state      = state_q;
   assign reveal     = reveal_q;

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker: expected outputs are queued when the
// stimulus is applied and popped and checked once the clock edge has acted.
module tb_guess_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Unit A uses default MAX_TRIES=7, unit B uses MAX_TRIES=2.
   logic       rst_a, seed_a, gb_a;
   logic [4:0] rand_a, guess_a;
   logic       th_a, tl_a, m_a;
   logic [3:0] tries_a;
   logic [2:0] st_a;
   logic [4:0] rev_a;

   logic       rst_b, seed_b, gb_b;
   logic [4:0] rand_b, guess_b;
   logic       th_b, tl_b, m_b;
   logic [3:0] tries_b;
   logic [2:0] st_b;
   logic [4:0] rev_b;

   guess_checker dut_a (
      .clk(clk), .rst(rst_a), .seed_button(seed_a), .rand_num(rand_a),
      .guess(guess_a), .guess_button(gb_a), .too_high(th_a), .too_low(tl_a),
      .match(m_a), .tries_left(tries_a), .state(st_a), .reveal(rev_a)
   );

   guess_checker #(.MAX_TRIES(2)) dut_b (
      .clk(clk), .rst(rst_b), .seed_button(seed_b), .rand_num(rand_b),
      .guess(guess_b), .guess_button(gb_b), .too_high(th_b), .too_low(tl_b),
      .match(m_b), .tries_left(tries_b), .state(st_b), .reveal(rev_b)
   );

   typedef struct {
      string       tag;
      int          unit;
      logic [14:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Expected vector layout: {state, too_high, too_low, match, tries_left, reveal}
   task automatic push_exp(input string tag, input int unit, input logic [2:0] st,
                           input logic th, input logic tl, input logic m,
                           input logic [3:0] tr, input logic [4:0] rv);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.exp  = {st, th, tl, m, tr, rv};
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop_check();
      exp_t        e;
      logic [14:0] obs;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.unit == 0) obs = {st_a, th_a, tl_a, m_a, tries_a, rev_a};
         else             obs = {st_b, th_b, tl_b, m_b, tries_b, rev_b};
         n_checks++;
         assert (obs === e.exp) begin
            n_pass++;
         end else begin
            $error("FAIL %s: observed st=%0d th=%0b tl=%0b m=%0b tries=%0d rev=%0d expected st=%0d th=%0b tl=%0b m=%0b tries=%0d rev=%0d",
                   e.tag, obs[14:12], obs[11], obs[10], obs[9], obs[8:5], obs[4:0],
                   e.exp[14:12], e.exp[11], e.exp[10], e.exp[9], e.exp[8:5], e.exp[4:0]);
         end
      end
   endtask

   // Push expectation, clock once, then compare.
   task automatic step(input string tag, input int unit, input logic [2:0] st,
                       input logic th, input logic tl, input logic m,
                       input logic [3:0] tr, input logic [4:0] rv);
      push_exp(tag, unit, st, th, tl, m, tr, rv);
      tick(1);
      pop_check();
   endtask

   initial begin
      rst_a = 1'b0; seed_a = 1'b1; gb_a = 1'b1; rand_a = 5'd0; guess_a = 5'd0;
      rst_b = 1'b0; seed_b = 1'b1; gb_b = 1'b1; rand_b = 5'd0; guess_b = 5'd0;
      tick(2);
      step("reset_a", 0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      rst_a = 1'b1;

      // Guess press in IDLE is ignored.
      guess_a = 5'd5; gb_a = 1'b0;
      step("idle_guess", 0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_a = 1'b1; tick(1);

      // Seed press -> SEEDING; guess press there is ignored.
      seed_a = 1'b0; rand_a = 5'd9;
      step("seeding", 0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_a = 1'b0;
      step("seeding_guess", 0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_a = 1'b1;
      tick(8);
      rand_a = 5'd13; seed_a = 1'b1;
      step("play_start", 0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 5'd0);
      rand_a = 5'd22;

      // Secret 13.
      guess_a = 5'd20; gb_a = 1'b0;
      step("guess20_high", 0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd6, 5'd0);
      gb_a = 1'b1;
      step("guess_release", 0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd6, 5'd0);
      guess_a = 5'd5; gb_a = 1'b0;
      step("guess5_low", 0, 3'd2, 1'b0, 1'b1, 1'b0, 4'd5, 5'd0);
      gb_a = 1'b1; tick(1);
      seed_a = 1'b0;
      step("play_seed_ignored", 0, 3'd2, 1'b0, 1'b1, 1'b0, 4'd5, 5'd0);
      seed_a = 1'b1; tick(1);
      guess_a = 5'd13; gb_a = 1'b0;
      step("guess13_win", 0, 3'd3, 1'b0, 1'b0, 1'b1, 4'd5, 5'd13);
      gb_a = 1'b1; tick(1);
      guess_a = 5'd0; gb_a = 1'b0;
      step("win_guess_ignored", 0, 3'd3, 1'b0, 1'b0, 1'b1, 4'd5, 5'd13);
      gb_a = 1'b1; tick(1);

      // New round, secret 31, guess 31 -> match.
      seed_a = 1'b0;
      step("reseed", 0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd5, 5'd0);
      rand_a = 5'd31; seed_a = 1'b1;
      step("play31", 0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 5'd0);
      guess_a = 5'd31; gb_a = 1'b0;
      step("guess31_match", 0, 3'd3, 1'b0, 1'b0, 1'b1, 4'd7, 5'd31);
      gb_a = 1'b1; tick(1);

      // New round, secret 0, guess 31 -> too_high; held button -> one decrement.
      seed_a = 1'b0; tick(1);
      rand_a = 5'd0; seed_a = 1'b1;
      step("play0", 0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 5'd0);
      guess_a = 5'd31; gb_a = 1'b0;
      step("secret0_guess31", 0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd6, 5'd0);
      tick(48);
      step("held50", 0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd6, 5'd0);
      gb_a = 1'b1; tick(1);
      for (int i = 0; i < 3; i++) begin
         gb_a = 1'b0; tick(1);
         gb_a = 1'b1; tick(1);
      end
      push_exp("tries3", 0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd3, 5'd0);
      pop_check();

      // Reset mid-round, with a guess press in the same cycle.
      rst_a = 1'b0; gb_a = 1'b0;
      step("midround_reset", 0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_a = 1'b1;

      // Seed held low through reset deassertion -> press on first active cycle.
      seed_a = 1'b0; tick(1);
      rst_a = 1'b1;
      step("held_through_reset", 0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      // Seed release and guess press together in SEEDING: guess not queued.
      rand_a = 5'd7; seed_a = 1'b1; guess_a = 5'd7; gb_a = 1'b0;
      step("simul_events", 0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 5'd0);
      step("no_queued_guess", 0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 5'd0);
      gb_a = 1'b1; tick(1);

      // Unit B: MAX_TRIES=2, secret 0.
      rst_b = 1'b1;
      seed_b = 1'b0;
      step("b_seeding", 1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
      rand_b = 5'd0; seed_b = 1'b1;
      step("b_play", 1, 3'd2, 1'b0, 1'b0, 1'b0, 4'd2, 5'd0);
      guess_b = 5'd1; gb_b = 1'b0;
      step("b_guess1", 1, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 5'd0);
      gb_b = 1'b1; tick(1);
      guess_b = 5'd2; gb_b = 1'b0;
      step("b_guess2_lose", 1, 3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_b = 1'b1; tick(1);
      guess_b = 5'd3; gb_b = 1'b0;
      step("b_lose_ignored", 1, 3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);
      gb_b = 1'b1; tick(1);
      seed_b = 1'b0;
      step("b_lose_reseed", 1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
